// File: rtl/egg_timer_ctrl_if.sv
// Egg-timer controller bus.
// Groups the debounced button pulses and the display/status outputs of the
// egg-timer sequencing controller.
//   start_p    start/pause pulse (one cycle)
//   set_p      set-mode pulse (one cycle)
//   inc_sec_p  increment preset seconds pulse
//   inc_min_p  increment preset minutes pulse
//   disp_min   BCD minutes shown (tens [7:4], units [3:0])
//   disp_sec   BCD seconds shown
//   state_led  one-hot state: IDLE=0001, RUN=0010, SET=0100, DONE=1000
//   blink      alarm blink, 1 blanks the display
//   tick       one-cycle pulse on each countdown decrement
// master: button source / display sink.  slave: the controller.
interface egg_timer_ctrl_if;
    logic       start_p;
    logic       set_p;
    logic       inc_sec_p;
    logic       inc_min_p;
    logic [7:0] disp_min;
    logic [7:0] disp_sec;
    logic [3:0] state_led;
    logic       blink;
    logic       tick;

    modport master (
        output start_p, set_p, inc_sec_p, inc_min_p,
        input  disp_min, disp_sec, state_led, blink, tick
    );

    modport slave (
        input  start_p, set_p, inc_sec_p, inc_min_p,
        output disp_min, disp_sec, state_led, blink, tick
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencing controller.
// Holds the BCD preset and live countdown, derives the countdown tick from
// clk_in, and runs the IDLE/SET/RUN/DONE machine from single-cycle button
// pulses. Drives display values, one-hot state LEDs, alarm blink and tick.
// Ports:
//   clk_in  single rising-edge clock
//   reset   synchronous, active-high
//   tif     egg_timer_ctrl_if.slave (buttons in; disp/state_led/blink/tick out)
module egg_timer_ctrl #(
    parameter int         TICK_DIV   = 5000000,
    parameter int         BLINK_DIV  = 2500000,
    parameter logic [7:0] PRESET_MIN = 8'h03,
    parameter logic [7:0] PRESET_SEC = 8'h00
) (
    input logic             clk_in,
    input logic             reset,
    egg_timer_ctrl_if.slave tif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // One-hot encoding equals the LED pattern, so state_led is the state register.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RUN  = 4'b0010,
        S_SET  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pre_min_q, pre_min_d;
    logic [7:0]    pre_sec_q, pre_sec_d;
    logic [7:0]    cnt_min_q, cnt_min_d;
    logic [7:0]    cnt_sec_q, cnt_sec_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          tick_q, tick_d;
    logic [7:0]    disp_min_q, disp_min_d;
    logic [7:0]    disp_sec_q, disp_sec_d;

    // Seconds increment over 00..59, wrapping without carry.
    function automatic logic [7:0] bcd_inc_sec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Minutes increment over 00..99, wrapping to 00.
    function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement; caller guarantees v != 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // One-second decrement of MM:SS with borrow; 00:00 stays 00:00.
    function automatic logic [15:0] dec_time(input logic [7:0] m, input logic [7:0] s);
        logic [15:0] r;
        if (s == 8'h00) begin
            r = (m == 8'h00) ? 16'h0000 : {bcd_dec(m), 8'h59};
        end else begin
            r = {m, bcd_dec(s)};
        end
        return r;
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pre_min_q   <= PRESET_MIN;
            pre_sec_q   <= PRESET_SEC;
            cnt_min_q   <= PRESET_MIN;
            cnt_sec_q   <= PRESET_SEC;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
            disp_min_q  <= PRESET_MIN;
            disp_sec_q  <= PRESET_SEC;
        end else begin
            state_q     <= state_d;
            pre_min_q   <= pre_min_d;
            pre_sec_q   <= pre_sec_d;
            cnt_min_q   <= cnt_min_d;
            cnt_sec_q   <= cnt_sec_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
            disp_min_q  <= disp_min_d;
            disp_sec_q  <= disp_sec_d;
        end
    end

    always_comb begin
        logic [15:0] dec_v;
        state_d     = state_q;
        pre_min_d   = pre_min_q;
        pre_sec_d   = pre_sec_q;
        cnt_min_d   = cnt_min_q;
        cnt_sec_d   = cnt_sec_q;
        tick_cnt_d  = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        tick_d      = 1'b0;
        dec_v       = dec_time(cnt_min_q, cnt_sec_q);

        case (state_q)
            S_IDLE: begin
                if (tif.start_p) begin
                    // A held non-zero count is a paused run and is resumed as-is.
                    if ({cnt_min_q, cnt_sec_q} == 16'h0000) begin
                        cnt_min_d = pre_min_q;
                        cnt_sec_d = pre_sec_q;
                    end
                    if ({cnt_min_d, cnt_sec_d} != 16'h0000) begin
                        state_d = S_RUN;
                    end
                end else if (tif.set_p) begin
                    state_d = S_SET;
                end
            end

            S_SET: begin
                if (tif.inc_sec_p) pre_sec_d = bcd_inc_sec(pre_sec_q);
                if (tif.inc_min_p) pre_min_d = bcd_inc_min(pre_min_q);
                // Leaving SET reloads the count from the just-updated preset.
                if (tif.start_p) begin
                    cnt_min_d = pre_min_d;
                    cnt_sec_d = pre_sec_d;
                    state_d   = ({pre_min_d, pre_sec_d} != 16'h0000) ? S_RUN : S_IDLE;
                end else if (tif.set_p) begin
                    cnt_min_d = pre_min_d;
                    cnt_sec_d = pre_sec_d;
                    state_d   = S_IDLE;
                end
            end

            S_RUN: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_d     = 1'b1;
                    cnt_min_d  = dec_v[15:8];
                    cnt_sec_d  = dec_v[7:0];
                    if (dec_v == 16'h0000) state_d = S_DONE;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
                // Buttons take effect after any same-cycle decrement.
                if (tif.start_p) begin
                    state_d = S_IDLE;
                end else if (tif.set_p) begin
                    state_d = S_SET;
                end
                if (state_d == S_DONE) begin
                    blink_d = 1'b1;
                end
                if (state_d != S_RUN) begin
                    tick_cnt_d = '0;
                end
            end

            S_DONE: begin
                cnt_min_d = 8'h00;
                cnt_sec_d = 8'h00;
                if (tif.start_p) begin
                    cnt_min_d = pre_min_q;
                    cnt_sec_d = pre_sec_q;
                    state_d   = S_IDLE;
                end else if (tif.set_p) begin
                    state_d = S_SET;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_d = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                    blink_d     = blink_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Display follows the state being entered so it stays aligned with state_led.
        disp_min_d = (state_d == S_SET) ? pre_min_d : cnt_min_d;
        disp_sec_d = (state_d == S_SET) ? pre_sec_d : cnt_sec_d;
    end

    assign tif.disp_min  = disp_min_q;
    assign tif.disp_sec  = disp_sec_q;
    assign tif.state_led = state_q;
    assign tif.blink     = blink_q;
    assign tif.tick      = tick_q;

endmodule
